// File: rtl/calc_arb_pkg.sv
// calc_arb_pkg: shared state encoding, data width and mode constants for calc_arb.
package calc_arb_pkg;
  localparam int DW = 16;
  typedef logic [DW-1:0] data_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;
endpackage

// File: rtl/calc_arb_rr_pick.sv
// rr_pick: combinational round-robin selector scanning last_i+1, last_i+2, ... modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = last_i;
    // Descending scan so the nearest requester after last_i is written last and wins.
    for (int k = N; k >= 1; k--)
      if (req_i[(int'(last_i) + k) % N]) idx_o = IW'((int'(last_i) + k) % N);
    any_o = |req_i;
  end
endmodule

// File: rtl/calc_arb.sv
// calc_arb: round-robin arbiter sequencing N requesters onto one shared add/sub unit.
// Define CALC_ARB_TIMEOUT_EN to add a WAIT timeout that returns an error response.
module calc_arb import calc_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int DW = calc_arb_pkg::DW,
  parameter int IW = $clog2(N)
`ifdef CALC_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic            CLK,
  input  logic            RESET_n,
  input  logic [N-1:0]    REQ_VALID,
  input  logic [N-1:0]    REQ_MODE,
  input  logic [N*DW-1:0] REQ_DATAA,
  input  logic [N*DW-1:0] REQ_DATAB,
  output logic [N-1:0]    REQ_READY,
  output logic [N-1:0]    RSP_VALID,
  output logic [IW-1:0]   RSP_ID,
  output logic [DW-1:0]   RSP_DATA,
  output logic            RSP_ERR,
  output logic            BUSY,
  output logic            CALC_MODE,
  output logic            CALC_SINK_VALID,
  output logic [DW-1:0]   CALC_SINK_DATAA,
  output logic [DW-1:0]   CALC_SINK_DATAB,
  input  logic            CALC_SOURCE_VALID,
  input  logic [DW-1:0]   CALC_SOURCE_DATA
);
  localparam logic [N-1:0] ONE = 1;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, g_q, rsp_id_q, win;
  logic [N-1:0] ready_q, rsp_valid_q;
  logic [DW-1:0] a_q, b_q, rsp_data_q;
  logic mode_q, sink_q, busy_q, any, to, done;
  rr_pick #(.N(N), .IW(IW)) u_pick (.req_i(REQ_VALID), .last_i(last_q), .idx_o(win), .any_o(any));
`ifdef CALC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic err_q;
  assign to = state_q == WAIT && !CALC_SOURCE_VALID && cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= state_q == WAIT ? cnt_q + 1'b1 : '0;
      if (done) err_q <= to;
    end
  assign RSP_ERR = err_q;
`else
  assign to = 1'b0;
  assign RSP_ERR = 1'b0;
`endif
  assign done = state_q == WAIT && (CALC_SOURCE_VALID || to);
  always_comb
    state_d = state_q == IDLE  ? (any ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (done ? RESP : WAIT) : IDLE;
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      state_q     <= IDLE;
      last_q      <= IW'(N - 1);
      g_q         <= '0;
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ready_q     <= '0;
      sink_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= state_d != IDLE;
      ready_q     <= '0;
      sink_q      <= 1'b0;
      rsp_valid_q <= '0;
      if (state_q == IDLE && any) begin
        g_q     <= win;
        last_q  <= win;
        mode_q  <= REQ_MODE[win];
        a_q     <= REQ_DATAA[int'(win)*DW +: DW];
        b_q     <= REQ_DATAB[int'(win)*DW +: DW];
        ready_q <= ONE << win;
        sink_q  <= 1'b1;
      end
      if (done) begin
        rsp_valid_q <= ONE << g_q;
        rsp_id_q    <= g_q;
        rsp_data_q  <= to ? '0 : CALC_SOURCE_DATA;
      end
    end
  assign REQ_READY       = ready_q;
  assign RSP_VALID       = rsp_valid_q;
  assign RSP_ID          = rsp_id_q;
  assign RSP_DATA        = rsp_data_q;
  assign BUSY            = busy_q;
  assign CALC_MODE       = mode_q;
  assign CALC_SINK_VALID = sink_q;
  assign CALC_SINK_DATAA = a_q;
  assign CALC_SINK_DATAB = b_q;
endmodule

// File: tb/tb_calc_arb.sv
// tb_calc_arb: table-driven checks of calc_arb against a sign-magnitude CALC stub.
module tb_calc_arb;
  logic CLK = 0, RESET_n = 0;
  logic [3:0] REQ_VALID = '0, REQ_MODE = '0;
  logic [63:0] REQ_DATAA = '0, REQ_DATAB = '0;
  logic [3:0] REQ_READY, RSP_VALID;
  logic [1:0] RSP_ID;
  logic [15:0] RSP_DATA, CALC_SINK_DATAA, CALC_SINK_DATAB;
  logic RSP_ERR, BUSY, CALC_MODE, CALC_SINK_VALID;
  logic CALC_SOURCE_VALID = 0;
  logic [15:0] CALC_SOURCE_DATA = '0;
  int errors = 0, checks = 0;
  calc_arb dut (
    .CLK(CLK), .RESET_n(RESET_n), .REQ_VALID(REQ_VALID), .REQ_MODE(REQ_MODE),
    .REQ_DATAA(REQ_DATAA), .REQ_DATAB(REQ_DATAB), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY), .CALC_MODE(CALC_MODE), .CALC_SINK_VALID(CALC_SINK_VALID),
    .CALC_SINK_DATAA(CALC_SINK_DATAA), .CALC_SINK_DATAB(CALC_SINK_DATAB),
    .CALC_SOURCE_VALID(CALC_SOURCE_VALID), .CALC_SOURCE_DATA(CALC_SOURCE_DATA)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] sm(input logic mode, input logic [15:0] a, input logic [15:0] b);
    int va, vb, r;
    va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
    r = mode ? va + vb : va - vb;
    return r < 0 ? {1'b1, 15'(-r)} : {1'b0, 15'(r)};
  endfunction
  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction
  // CALC stub: result appears lat cycles after the SINK_VALID cycle; keeps running through DUT reset.
  logic stub_on = 1;
  int lat = 1, cnt = 0, pulses = 0;
  logic [15:0] res_h = '0;
  always @(posedge CLK) begin
    CALC_SOURCE_VALID <= 1'b0;
    if (stub_on && CALC_SINK_VALID) begin
      if (lat == 1) begin
        CALC_SOURCE_VALID <= 1'b1;
        CALC_SOURCE_DATA  <= sm(CALC_MODE, CALC_SINK_DATAA, CALC_SINK_DATAB);
        pulses <= pulses + 1;
      end else begin
        cnt   <= lat - 1;
        res_h <= sm(CALC_MODE, CALC_SINK_DATAA, CALC_SINK_DATAB);
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        CALC_SOURCE_VALID <= 1'b1;
        CALC_SOURCE_DATA  <= res_h;
        pulses <= pulses + 1;
      end
    end
  end
  typedef struct {
    int idx;
    logic mode;
    logic [15:0] a, b, r;
    int lat;
  } vec_t;
  vec_t v[5];
  int gi[$], gc[$];
  initial begin
    int k, sinks, rsps, busy_low, p0, busy_hi, rsp_seen, bad;
    logic reasserted;
    int exp_g[4];
    v[0] = '{1, 1'b1, 16'h0003, 16'h0005, 16'h0008, 1};
    v[1] = '{2, 1'b0, 16'h0005, 16'h0002, 16'h0003, 1};
    v[2] = '{0, 1'b1, 16'h8002, 16'h0001, 16'h8001, 3};
    v[3] = '{1, 1'b1, 16'h0010, 16'h8010, 16'h0000, 4};
    v[4] = '{3, 1'b0, 16'h8004, 16'h8001, 16'h8003, 2};
    exp_g = '{0, 2, 3, 0};
    repeat (2) @(negedge CLK);
    chk("reset_ctrl", {REQ_READY, RSP_VALID, RSP_ID, RSP_ERR, BUSY, CALC_MODE, CALC_SINK_VALID}, 0);
    chk("reset_data", {RSP_DATA, CALC_SINK_DATAA}, 0);
    RESET_n = 1;
    @(negedge CLK);
    // Fairness: 0,2,3 together, 0 re-requests the cycle after its grant.
    REQ_MODE = 4'b1111;
    REQ_DATAA = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    REQ_DATAB = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    REQ_VALID = 4'b1101;
    sinks = 0; rsps = 0; busy_low = 0; reasserted = 0; bad = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if (CALC_SINK_VALID) sinks++;
      if (RSP_VALID != 0) rsps++;
      if (gi.size() > 0 && gi.size() < 4 && !BUSY) busy_low++;
      if (REQ_READY != 0) begin
        if ($countones(REQ_READY) != 1) bad++;
        gi.push_back(oh2i(REQ_READY));
        gc.push_back(c);
        REQ_VALID[oh2i(REQ_READY)] = 1'b0;
      end else if (!reasserted && gi.size() == 1) begin
        REQ_VALID[0] = 1'b1;
        reasserted = 1;
      end
    end
    chk("grant_count", gi.size(), 4);
    for (int i = 0; i < 4; i++) chk("grant_order", i < gi.size() ? gi[i] : -1, exp_g[i]);
    for (int i = 1; i < 4; i++) chk("grant_spacing", i < gc.size() ? gc[i] - gc[i-1] : -1, 4);
    chk("ready_onehot", bad, 0);
    chk("sink_pulses", sinks, 4);
    chk("rsp_pulses", rsps, 4);
    chk("busy_low_cycles", busy_low, 3);
    // Table-driven single transactions with varying CALC latency.
    foreach (v[i]) begin
      lat = v[i].lat;
      REQ_MODE[v[i].idx] = v[i].mode;
      REQ_DATAA[v[i].idx*16 +: 16] = v[i].a;
      REQ_DATAB[v[i].idx*16 +: 16] = v[i].b;
      REQ_VALID[v[i].idx] = 1'b1;
      k = 0;
      while (k < 10 && REQ_READY == 0) begin @(negedge CLK); k++; end
      chk("ready_seen", REQ_READY != 0, 1);
      chk("ready_vec", REQ_READY, 1 << v[i].idx);
      chk("sink_valid", CALC_SINK_VALID, 1);
      chk("calc_mode", CALC_MODE, v[i].mode);
      chk("calc_ab", {CALC_SINK_DATAA, CALC_SINK_DATAB}, {v[i].a, v[i].b});
      REQ_VALID[v[i].idx] = 1'b0;
      k = 0;
      while (k < 40 && RSP_VALID == 0) begin @(negedge CLK); k++; end
      chk("rsp_latency", k, v[i].lat + 1);
      chk("rsp_vec", RSP_VALID, 1 << v[i].idx);
      chk("rsp_id", RSP_ID, v[i].idx);
      chk("rsp_data", RSP_DATA, v[i].r);
      chk("rsp_err", RSP_ERR, 0);
    end
    repeat (2) @(negedge CLK);
    chk("hold_rsp", {RSP_DATA, 14'b0, RSP_ID}, {16'h8003, 16'h0003});
    chk("hold_calc", {CALC_SINK_DATAA, 15'b0, CALC_MODE}, {16'h8004, 16'h0000});
    chk("idle_quiet", {RSP_VALID, BUSY}, 0);
    // Non-responding CALC.
    stub_on = 0;
    REQ_MODE[2] = 1'b1;
    REQ_DATAA[32 +: 16] = 16'h1234;
    REQ_VALID[2] = 1'b1;
    k = 0;
    while (k < 10 && REQ_READY == 0) begin @(negedge CLK); k++; end
    chk("nr_ready", REQ_READY, 4'b0100);
    REQ_VALID[2] = 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
    k = 0;
    while (k < 40 && RSP_VALID == 0) begin @(negedge CLK); k++; end
    chk("to_latency", k, 16);
    chk("to_vec", RSP_VALID, 4'b0100);
    chk("to_err", RSP_ERR, 1);
    chk("to_data", RSP_DATA, 0);
`else
    busy_hi = 0; rsp_seen = 0;
    repeat (50) begin
      @(negedge CLK);
      if (BUSY) busy_hi++;
      if (RSP_VALID != 0) rsp_seen++;
    end
    chk("hang_busy", busy_hi, 50);
    chk("hang_no_rsp", rsp_seen, 0);
`endif
    RESET_n = 0;
    @(negedge CLK);
    RESET_n = 1;
    stub_on = 1;
    lat = 5;
    @(negedge CLK);
    // Reset in WAIT; the stale result then lands in IDLE.
    REQ_MODE[0] = 1'b1;
    REQ_DATAA[15:0] = 16'h0007;
    REQ_DATAB[15:0] = 16'h0002;
    REQ_VALID[0] = 1'b1;
    k = 0;
    while (k < 10 && REQ_READY == 0) begin @(negedge CLK); k++; end
    chk("st_ready", REQ_READY, 4'b0001);
    REQ_VALID[0] = 1'b0;
    repeat (2) @(negedge CLK);
    p0 = pulses;
    RESET_n = 0;
    #1;
    chk("arst_ctrl", {REQ_READY, RSP_VALID, RSP_ID, RSP_ERR, BUSY, CALC_MODE, CALC_SINK_VALID}, 0);
    chk("arst_data", {CALC_SINK_DATAA, CALC_SINK_DATAB}, 0);
    @(negedge CLK);
    RESET_n = 1;
    busy_hi = 0; rsp_seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (BUSY) busy_hi++;
      if (RSP_VALID != 0) rsp_seen++;
    end
    chk("stale_pulse_sent", pulses - p0, 1);
    chk("stale_no_rsp", rsp_seen, 0);
    chk("stale_no_busy", busy_hi, 0);
    lat = 1;
    REQ_VALID = 4'b0011;
    k = 0;
    while (k < 10 && REQ_READY == 0) begin @(negedge CLK); k++; end
    chk("post_reset_winner", REQ_READY, 4'b0001);
    REQ_VALID = '0;
    repeat (6) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
